// File: rtl/sdram_soc_bridge.sv
// sdram_soc_bridge: in-order request FIFO feeding a single-outstanding SDRAM controller command FSM.
// Define SDRAM_BRIDGE_READ_TIMEOUT_EN to enable the read-response timeout (TIMEOUT_CYCLES).
module sdram_soc_bridge #(
   parameter int FIFO_DEPTH     = 4,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic        clk,
   input  logic        reset_port,
   input  logic        cpu_side_req_valid_port,
   output logic        cpu_side_req_ready_port,
   input  logic        cpu_side_req_wr_port,
   input  logic [22:0] cpu_side_req_addr_port,
   input  logic [31:0] cpu_side_req_wr_data_port,
   input  logic [3:0]  cpu_side_req_wr_mask_port,
   output logic        cpu_side_rsp_valid_port,
   output logic [31:0] cpu_side_rsp_data_port,
   output logic        cpu_side_rsp_err_port,
   input  logic        soc_side_busy_port,
   input  logic        soc_side_ready_port,
   input  logic [31:0] soc_side_rd_data_port,
   output logic [22:0] soc_side_addr_port,
   output logic [31:0] soc_side_wr_data_port,
   output logic [3:0]  soc_side_wr_mask_port,
   output logic        soc_side_wr_en_port,
   output logic        soc_side_rd_en_port
);
   localparam int AW = $clog2(FIFO_DEPTH);
   typedef struct packed {
      logic        wr;
      logic [22:0] addr;
      logic [31:0] data;
      logic [3:0]  mask;
   } req_t;
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACCEPT, WAIT_DONE} state_t;

   if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_param
      $error("sdram_soc_bridge: illegal FIFO_DEPTH or TIMEOUT_CYCLES");
   end

   req_t          fifo_q [FIFO_DEPTH];
   req_t          cmd_q, cmd_d;
   state_t        state_q, state_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          rsp_valid_q, rsp_valid_d;
   logic [31:0]   rsp_data_q, rsp_data_d;
   logic          push, pop, rd_done, wr_done, waiting, tmo_hit;

   assign cpu_side_req_ready_port = count_q != (AW+1)'(FIFO_DEPTH);
   assign push    = cpu_side_req_valid_port && cpu_side_req_ready_port;
   assign pop     = state_q == IDLE && count_q != '0 && !soc_side_busy_port;
   assign waiting = state_q == WAIT_ACCEPT || state_q == WAIT_DONE;
   assign rd_done = state_q == WAIT_DONE && !cmd_q.wr && soc_side_ready_port;
   assign wr_done = state_q == WAIT_DONE && cmd_q.wr && !soc_side_busy_port;

   always_comb begin
      wr_ptr_d    = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d    = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d     = count_q + (AW+1)'(push) - (AW+1)'(pop);
      cmd_d       = pop ? fifo_q[rd_ptr_q] : cmd_q;
      rsp_valid_d = rd_done || tmo_hit;
      rsp_data_d  = rd_done ? soc_side_rd_data_port : (tmo_hit ? 32'hDEAD_BEEF : rsp_data_q);
      state_d     = state_q;
      case (state_q)
         IDLE:        state_d = pop ? ISSUE : IDLE;
         ISSUE:       state_d = WAIT_ACCEPT;
         WAIT_ACCEPT: state_d = soc_side_busy_port ? WAIT_DONE : WAIT_ACCEPT;
         WAIT_DONE:   state_d = (rd_done || wr_done) ? IDLE : WAIT_DONE;
         default:     state_d = IDLE;
      endcase
      if (tmo_hit) state_d = IDLE;
   end

   always_ff @(posedge clk or posedge reset_port) begin
      if (reset_port) begin
         state_q     <= IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         cmd_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         cmd_q       <= cmd_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
      end
   end

   // Queue storage needs no reset: occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (push) fifo_q[wr_ptr_q] <= {cpu_side_req_wr_port, cpu_side_req_addr_port,
                                     cpu_side_req_wr_data_port, cpu_side_req_wr_mask_port};
   end

`ifdef SDRAM_BRIDGE_READ_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          rsp_err_q, rsp_err_d;

   // A real answer arriving on the last allowed cycle wins over the timeout.
   always_comb begin
      tmo_d     = (state_q == ISSUE) ? '0 : (waiting ? tmo_q + 1'b1 : tmo_q);
      tmo_hit   = waiting && !cmd_q.wr && tmo_q == TW'(TIMEOUT_CYCLES - 1) && !rd_done;
      rsp_err_d = tmo_hit ? 1'b1 : (rd_done ? 1'b0 : rsp_err_q);
   end

   always_ff @(posedge clk or posedge reset_port) begin
      if (reset_port) begin
         tmo_q     <= '0;
         rsp_err_q <= 1'b0;
      end else begin
         tmo_q     <= tmo_d;
         rsp_err_q <= rsp_err_d;
      end
   end

   assign cpu_side_rsp_err_port = rsp_err_q;
`else
   assign tmo_hit               = 1'b0;
   assign cpu_side_rsp_err_port = 1'b0;
`endif

   assign cpu_side_rsp_valid_port = rsp_valid_q;
   assign cpu_side_rsp_data_port  = rsp_data_q;
   assign soc_side_addr_port      = cmd_q.addr;
   assign soc_side_wr_data_port   = cmd_q.data;
   assign soc_side_wr_mask_port   = cmd_q.mask;
   assign soc_side_wr_en_port     = state_q == ISSUE && cmd_q.wr;
   assign soc_side_rd_en_port     = state_q == ISSUE && !cmd_q.wr;
endmodule

// File: tb/tb_sdram_soc_bridge.sv
// tb_sdram_soc_bridge: directed bench for sdram_soc_bridge with a behavioural SDRAM controller model.
// The read-timeout scenario runs only when SDRAM_BRIDGE_READ_TIMEOUT_EN is defined.
module tb_sdram_soc_bridge;
   logic        clk = 1'b0;
   logic        reset_port;
   logic        req_valid, req_ready, req_wr;
   logic [22:0] req_addr;
   logic [31:0] req_data;
   logic [3:0]  req_mask;
   logic        rsp_valid, rsp_err;
   logic [31:0] rsp_data;
   logic        soc_busy = 1'b0, soc_ready = 1'b0;
   logic [31:0] soc_rd_data = 32'h0;
   logic [22:0] soc_addr;
   logic [31:0] soc_wr_data;
   logic [3:0]  soc_mask;
   logic        wr_en, rd_en;

   always #5 clk = ~clk;

   sdram_soc_bridge #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .reset_port(reset_port),
      .cpu_side_req_valid_port(req_valid), .cpu_side_req_ready_port(req_ready),
      .cpu_side_req_wr_port(req_wr), .cpu_side_req_addr_port(req_addr),
      .cpu_side_req_wr_data_port(req_data), .cpu_side_req_wr_mask_port(req_mask),
      .cpu_side_rsp_valid_port(rsp_valid), .cpu_side_rsp_data_port(rsp_data),
      .cpu_side_rsp_err_port(rsp_err),
      .soc_side_busy_port(soc_busy), .soc_side_ready_port(soc_ready),
      .soc_side_rd_data_port(soc_rd_data),
      .soc_side_addr_port(soc_addr), .soc_side_wr_data_port(soc_wr_data),
      .soc_side_wr_mask_port(soc_mask),
      .soc_side_wr_en_port(wr_en), .soc_side_rd_en_port(rd_en)
   );

   int tests = 0, fails = 0, cyc = 0;
   logic [31:0] mem [logic [22:0]];
   logic [31:0] pend = 32'h0;
   int  busy_len = 4, rd_lat = 6, busy_cnt = 0, rd_cnt = 0, inject_cyc = -1;
   bit  hold_busy = 1'b0, no_answer = 1'b0;
   logic [22:0] iss_addr [$];
   logic [31:0] rsp_dq [$];
   logic        rsp_eq [$];
   int  wr_n = 0, rd_n = 0, rsp_n = 0, both_n = 0, rd_cyc = 0, rsp_cyc = 0, last_iss = -100, min_gap = 1000;

   always @(posedge clk) cyc <= cyc + 1;

   // Controller model and monitor, evaluated mid-cycle.
   always @(negedge clk) begin
      soc_ready = 1'b0;
      if (busy_cnt > 0) busy_cnt--;
      if (rd_cnt > 0) begin
         rd_cnt--;
         if (rd_cnt == 0 && !no_answer) begin
            soc_ready   = 1'b1;
            soc_rd_data = pend;
         end
      end
      if (cyc == inject_cyc) begin
         soc_ready   = 1'b1;
         soc_rd_data = 32'hBAD0_BAD0;
      end
      if (wr_en || rd_en) begin
         iss_addr.push_back(soc_addr);
         busy_cnt = busy_len;
         if (cyc - last_iss < min_gap) min_gap = cyc - last_iss;
         last_iss = cyc;
      end
      if (wr_en && rd_en) both_n++;
      if (wr_en) begin
         wr_n++;
         mem[soc_addr] = soc_wr_data;
      end
      if (rd_en) begin
         rd_n++;
         rd_cyc = cyc;
         rd_cnt = rd_lat;
         pend   = mem.exists(soc_addr) ? mem[soc_addr] : 32'h0;
      end
      if (rsp_valid) begin
         rsp_n++;
         rsp_cyc = cyc;
         rsp_dq.push_back(rsp_data);
         rsp_eq.push_back(rsp_err);
      end
      soc_busy = hold_busy || busy_cnt > 0;
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic push(input logic wr, input logic [22:0] addr, input logic [31:0] data);
      int n = 0;
      req_valid = 1'b1; req_wr = wr; req_addr = addr; req_data = data; req_mask = 4'hF;
      while (!req_ready && n < 200) begin
         step(1);
         n++;
      end
      if (n >= 200) check("push_timeout", 64'(req_ready), 64'd1);
      step(1);
      req_valid = 1'b0;
   endtask

   task automatic wait_rsp(input int target, input string tag);
      int n = 0;
      while (rsp_n < target && n < 200) begin
         step(1);
         n++;
      end
      check(tag, 64'(rsp_n >= target), 64'd1);
   endtask

   task automatic wait_iss(input int target, input string tag);
      int n = 0;
      while (iss_addr.size() < target && n < 200) begin
         step(1);
         n++;
      end
      check(tag, 64'(iss_addr.size() >= target), 64'd1);
   endtask

   initial begin
      int b_iss, b_rsp, b_wr, b_rd;
      reset_port = 1'b1; req_valid = 1'b0; req_wr = 1'b0;
      req_addr = '0; req_data = '0; req_mask = '0;
      mem[23'h7F_FFFF] = 32'h1234_5678;
      step(5);
      check("rst_ready", 64'(req_ready), 64'd1);
      check("rst_strobes", 64'({wr_en, rd_en, rsp_valid}), 64'd0);
      reset_port = 1'b0;
      step(1);
      check("rel_ready", 64'(req_ready), 64'd1);
      check("rel_strobes", 64'({wr_en, rd_en, rsp_valid}), 64'd0);
      check("rel_soc_fields", 64'({soc_addr, soc_wr_data, soc_mask}), 64'd0);
      check("rel_rsp_fields", 64'({rsp_data, rsp_err}), 64'd0);

      // Single write
      b_wr = wr_n; b_rd = rd_n; b_rsp = rsp_n; b_iss = iss_addr.size();
      push(1'b1, 23'h00_0010, 32'hA5A5_5A5A);
      step(15);
      check("wr_pulses", 64'(wr_n - b_wr), 64'd1);
      check("wr_no_rd", 64'(rd_n - b_rd), 64'd0);
      check("wr_no_rsp", 64'(rsp_n - b_rsp), 64'd0);
      check("wr_issued_addr", 64'(iss_addr[b_iss]), 64'h10);
      check("wr_hold_addr", 64'(soc_addr), 64'h10);
      check("wr_hold_data", 64'(soc_wr_data), 64'hA5A5_5A5A);
      check("wr_hold_mask", 64'(soc_mask), 64'hF);

      // Stray ready while idle must not produce a response
      b_rsp = rsp_n;
      inject_cyc = cyc;
      step(5);
      check("stray_ready_ignored", 64'(rsp_n - b_rsp), 64'd0);

      // Single read, answered 6 cycles after rd_en
      rd_lat = 6; b_rd = rd_n; b_rsp = rsp_n;
      push(1'b0, 23'h7F_FFFF, 32'h0);
      wait_rsp(b_rsp + 1, "rd_rsp_seen");
      step(3);
      check("rd_rsp_count", 64'(rsp_n - b_rsp), 64'd1);
      check("rd_data", 64'(rsp_dq[b_rsp]), 64'h1234_5678);
      check("rd_err", 64'(rsp_eq[b_rsp]), 64'd0);
      check("rd_latency", 64'(rsp_cyc - rd_cyc), 64'd7);
      check("rd_en_count", 64'(rd_n - b_rd), 64'd1);
      check("rd_hold_addr", 64'(soc_addr), 64'h7F_FFFF);

      // Queue fills while controller is busy
      hold_busy = 1'b1;
      step(2);
      b_iss = iss_addr.size();
      for (int i = 0; i < 4; i++) begin
         push(1'b1, 23'h100 + 23'(i), 32'hC000_0000 + 32'(i));
         check($sformatf("fifo_ready_after_%0d", i + 1), 64'(req_ready), (i < 3) ? 64'd1 : 64'd0);
      end
      req_valid = 1'b1; req_wr = 1'b1; req_addr = 23'h104; req_data = 32'hC000_0004;
      step(5);
      check("fifo_stall_ready", 64'(req_ready), 64'd0);
      check("fifo_no_issue_busy", 64'(iss_addr.size() - b_iss), 64'd0);
      hold_busy = 1'b0;
      push(1'b1, 23'h104, 32'hC000_0004);
      wait_iss(b_iss + 5, "fifo_all_issued");
      for (int i = 0; i < 5; i++)
         check($sformatf("fifo_order_%0d", i), 64'(iss_addr[b_iss + i]), 64'(23'h100 + i));
      step(10);

      // W,R,W,R to one address
      rd_lat = 3; b_rsp = rsp_n;
      push(1'b1, 23'h55, 32'h1111_1111);
      push(1'b0, 23'h55, 32'h0);
      push(1'b1, 23'h55, 32'h2222_2222);
      push(1'b0, 23'h55, 32'h0);
      wait_rsp(b_rsp + 2, "mix_rsp_seen");
      check("mix_rd0", 64'(rsp_dq[b_rsp]), 64'h1111_1111);
      check("mix_rd1", 64'(rsp_dq[b_rsp + 1]), 64'h2222_2222);
      check("mix_err", 64'({rsp_eq[b_rsp], rsp_eq[b_rsp + 1]}), 64'd0);
      step(10);
      check("issue_spacing_ge3", 64'(min_gap >= 3), 64'd1);
      check("never_both_strobes", 64'(both_n), 64'd0);

`ifdef SDRAM_BRIDGE_READ_TIMEOUT_EN
      // Unanswered read times out, then the queued write proceeds
      no_answer = 1'b1; b_rsp = rsp_n; b_iss = iss_addr.size();
      push(1'b0, 23'h20, 32'h0);
      push(1'b1, 23'h30, 32'h3030_3030);
      wait_rsp(b_rsp + 1, "tmo_rsp_seen");
      check("tmo_data", 64'(rsp_dq[b_rsp]), 64'hDEAD_BEEF);
      check("tmo_err", 64'(rsp_eq[b_rsp]), 64'd1);
      no_answer = 1'b0;
      wait_iss(b_iss + 2, "tmo_next_issued");
      check("tmo_next_addr", 64'(iss_addr[b_iss + 1]), 64'h30);
      step(10);
`endif

      // Reset while a read is in flight and a write is queued
      no_answer = 1'b1; b_rsp = rsp_n; b_wr = wr_n;
      push(1'b0, 23'h66, 32'h0);
      push(1'b1, 23'h67, 32'h0000_0077);
      step(6);
      reset_port = 1'b1;
      step(2);
      check("midrst_ready", 64'(req_ready), 64'd1);
      check("midrst_strobes", 64'({wr_en, rd_en, rsp_valid}), 64'd0);
      check("midrst_soc_fields", 64'({soc_addr, soc_wr_data, soc_mask}), 64'd0);
      reset_port = 1'b0;
      no_answer = 1'b0;
      step(20);
      check("midrst_no_rsp", 64'(rsp_n - b_rsp), 64'd0);
      check("midrst_wr_discarded", 64'(wr_n - b_wr), 64'd0);
      check("midrst_addr_clear", 64'(soc_addr), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
